sram_cycle_seq: RTL and testbench

//  Sequences Zorro-side SRAM accesses after address decode has selected the board RAM (ram1ce).

---
 rtl/sram_cycle_seq_pkg.sv | 43 ++++
 rtl/sram_cycle_seq_if.sv | 40 ++++
 rtl/sram_cycle_seq.sv | 134 +++++++++++++
 tb/tb_sram_cycle_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_cycle_seq_pkg.sv
// Shared types and constants for the Zorro-side SRAM cycle sequencer.
package sram_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ACCESS = 2'd2,
        ACK    = 2'd3
    } state_t;

    // Width of the saturating timeout counter.
    localparam int TIMEOUT_W = 7;

    // Active-low strobes and lanes rest at this level.
    localparam logic STROBE_OFF = 1'b1;

    // Registered output bundle; every field leaves the block straight from a flop.
    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
        logic buf_oe;
        logic buf_dir;
        logic dtack;
        logic timeout;
    } ctrl_t;

    // Output values in IDLE and after reset: SRAM deselected, buffer off, read direction.
    localparam ctrl_t CTRL_IDLE = '{
        ce_n:    STROBE_OFF,
        oe_n:    STROBE_OFF,
        we_n:    STROBE_OFF,
        ub_n:    STROBE_OFF,
        lb_n:    STROBE_OFF,
        buf_oe:  1'b0,
        buf_dir: 1'b1,
        dtack:   1'b0,
        timeout: 1'b0
    };

endpackage

// File: rtl/sram_cycle_seq_if.sv
// Bus bundle between the 68000/decoder side and the SRAM sequencer.
// Handshake: a cycle starts when _AS is sampled low with ram_sel high; the
// sequencer answers with dtack, which stays high until _AS is sampled high
// again. _AS rising before dtack aborts the cycle and no dtack is given.
interface sram_cycle_seq_if;
    import sram_seq_pkg::*;

    logic   _AS;
    logic   _UDS;
    logic   _LDS;
    logic   RW;
    logic   ram_sel;
    logic   wr_prot;

    logic   _RAM_CE;
    logic   _RAM_OE;
    logic   _RAM_WE;
    logic   _RAM_UB;
    logic   _RAM_LB;
    logic   buf_oe;
    logic   buf_dir;
    logic   dtack;
    logic   timeout;

    // Current sequencer state, exported for debug and checkers.
    state_t dbg_state;

    modport master (
        output _AS, _UDS, _LDS, RW, ram_sel, wr_prot,
        input  _RAM_CE, _RAM_OE, _RAM_WE, _RAM_UB, _RAM_LB,
        input  buf_oe, buf_dir, dtack, timeout, dbg_state
    );

    modport slave (
        input  _AS, _UDS, _LDS, RW, ram_sel, wr_prot,
        output _RAM_CE, _RAM_OE, _RAM_WE, _RAM_UB, _RAM_LB,
        output buf_oe, buf_dir, dtack, timeout, dbg_state
    );

endinterface

// File: rtl/sram_cycle_seq.sv
// SRAM cycle sequencer: turns 68000 strobes into SRAM CE/OE/WE/lane timing,
// drives the 74x245 buffer and returns a DTACK after programmable wait states.
module sram_cycle_seq
    import sram_seq_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 64
) (
    input  logic               CLK,
    input  logic               _RST,
    sram_cycle_seq_if.slave    bus
);

    localparam logic [2:0]           WS_LAST = 3'(WAIT_STATES);
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] TO_SAT  = '1;

    state_t               state, nxt_state;
    ctrl_t                ctrl, nxt_ctrl;
    logic [2:0]           wcnt, nxt_wcnt;
    logic [TIMEOUT_W-1:0] tcnt, nxt_tcnt;
    // After a timeout _AS may still be low; lock blocks a restart until _AS is seen high.
    logic                 lock, nxt_lock;
    logic                 go;

    assign go = !bus._AS && bus.ram_sel;

    // State, counters and all outputs are registered; reset is asynchronous.
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state <= IDLE;
            ctrl  <= CTRL_IDLE;
            wcnt  <= '0;
            tcnt  <= '0;
            lock  <= 1'b0;
        end else begin
            state <= nxt_state;
            ctrl  <= nxt_ctrl;
            wcnt  <= nxt_wcnt;
            tcnt  <= nxt_tcnt;
            lock  <= nxt_lock;
        end
    end

    // Next-state and next-output decode; outputs hold unless a transition changes them.
    always_comb begin
        nxt_state        = state;
        nxt_ctrl         = ctrl;
        nxt_ctrl.timeout = 1'b0;
        nxt_wcnt         = wcnt;
        nxt_lock         = lock && !bus._AS;
        if (state == IDLE) begin
            nxt_tcnt = '0;
        end else if (tcnt == TO_SAT) begin
            nxt_tcnt = tcnt;
        end else begin
            nxt_tcnt = tcnt + 7'd1;
        end

        case (state)
            IDLE: begin
                nxt_ctrl = CTRL_IDLE;
                nxt_wcnt = '0;
                if (go && !lock) begin
                    nxt_state        = SELECT;
                    nxt_ctrl.ce_n    = 1'b0;
                    nxt_ctrl.buf_dir = bus.RW;
                end
            end
            SELECT: begin
                if (bus._AS) begin
                    nxt_state = IDLE;
                    nxt_ctrl  = CTRL_IDLE;
                end else if (bus.RW) begin
                    nxt_state       = ACCESS;
                    nxt_ctrl.oe_n   = 1'b0;
                    nxt_ctrl.buf_oe = 1'b1;
                    nxt_ctrl.ub_n   = bus._UDS;
                    nxt_ctrl.lb_n   = bus._LDS;
                end else if (!bus._UDS || !bus._LDS) begin
                    // Write data strobes trail _AS by a clock, so lanes are taken here.
                    nxt_state       = ACCESS;
                    nxt_ctrl.buf_oe = 1'b1;
                    nxt_ctrl.ub_n   = bus._UDS;
                    nxt_ctrl.lb_n   = bus._LDS;
                    nxt_ctrl.we_n   = bus.wr_prot;
                end
            end
            ACCESS: begin
                if (bus._AS) begin
                    nxt_state = IDLE;
                    nxt_ctrl  = CTRL_IDLE;
                end else if (wcnt == WS_LAST) begin
                    // WE rises with dtack so the write ends while CE/data are still held.
                    nxt_state      = ACK;
                    nxt_ctrl.dtack = 1'b1;
                    nxt_ctrl.we_n  = STROBE_OFF;
                end else begin
                    nxt_wcnt = wcnt + 3'd1;
                end
            end
            ACK: begin
                if (bus._AS) begin
                    nxt_state = IDLE;
                    nxt_ctrl  = CTRL_IDLE;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_ctrl  = CTRL_IDLE;
            end
        endcase

        // Stuck-cycle guard overrides everything else.
        if (state != IDLE && tcnt == TO_LAST) begin
            nxt_state        = IDLE;
            nxt_ctrl         = CTRL_IDLE;
            nxt_ctrl.timeout = 1'b1;
            nxt_lock         = !bus._AS;
        end
    end

    assign bus._RAM_CE   = ctrl.ce_n;
    assign bus._RAM_OE   = ctrl.oe_n;
    assign bus._RAM_WE   = ctrl.we_n;
    assign bus._RAM_UB   = ctrl.ub_n;
    assign bus._RAM_LB   = ctrl.lb_n;
    assign bus.buf_oe    = ctrl.buf_oe;
    assign bus.buf_dir   = ctrl.buf_dir;
    assign bus.dtack     = ctrl.dtack;
    assign bus.timeout   = ctrl.timeout;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_sram_cycle_seq.sv
// Bench for sram_cycle_seq: three instances (WAIT_STATES 1, 0, 3) share one stimulus.
module tb_sram_cycle_seq;
    import sram_seq_pkg::*;

    // Output bit order: ce oe we ub lb buf_oe buf_dir dtack timeout
    localparam logic [8:0] IDL = 9'b111110100;

    typedef struct {
        logic [5:0] ins;   // as uds lds rw sel prot
        logic [8:0] exp;
        state_t     st;
    } vec_t;

    logic clk;
    logic rst_n;
    logic as_n, uds_n, lds_n, rw, ram_sel, wr_prot;
    int   vectors;
    int   miscompares;

    sram_cycle_seq_if if1 ();
    sram_cycle_seq_if if0 ();
    sram_cycle_seq_if if3 ();

    assign if1._AS = as_n;   assign if0._AS = as_n;   assign if3._AS = as_n;
    assign if1._UDS = uds_n; assign if0._UDS = uds_n; assign if3._UDS = uds_n;
    assign if1._LDS = lds_n; assign if0._LDS = lds_n; assign if3._LDS = lds_n;
    assign if1.RW = rw;      assign if0.RW = rw;      assign if3.RW = rw;
    assign if1.ram_sel = ram_sel; assign if0.ram_sel = ram_sel; assign if3.ram_sel = ram_sel;
    assign if1.wr_prot = wr_prot; assign if0.wr_prot = wr_prot; assign if3.wr_prot = wr_prot;

    sram_cycle_seq #(.WAIT_STATES(1), .TIMEOUT(64)) dut1 (.CLK(clk), ._RST(rst_n), .bus(if1.slave));
    sram_cycle_seq #(.WAIT_STATES(0), .TIMEOUT(64)) dut0 (.CLK(clk), ._RST(rst_n), .bus(if0.slave));
    sram_cycle_seq #(.WAIT_STATES(3), .TIMEOUT(64)) dut3 (.CLK(clk), ._RST(rst_n), .bus(if3.slave));

    logic [8:0] out1, out0, out3;
    assign out1 = {if1._RAM_CE, if1._RAM_OE, if1._RAM_WE, if1._RAM_UB, if1._RAM_LB,
                   if1.buf_oe, if1.buf_dir, if1.dtack, if1.timeout};
    assign out0 = {if0._RAM_CE, if0._RAM_OE, if0._RAM_WE, if0._RAM_UB, if0._RAM_LB,
                   if0.buf_oe, if0.buf_dir, if0.dtack, if0.timeout};
    assign out3 = {if3._RAM_CE, if3._RAM_OE, if3._RAM_WE, if3._RAM_UB, if3._RAM_LB,
                   if3.buf_oe, if3.buf_dir, if3.dtack, if3.timeout};

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic check_st(input string name, input state_t got, input state_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%s exp=%s", name, got.name(), exp.name());
        end
    endtask

    task automatic drive(input logic [5:0] ins);
        {as_n, uds_n, lds_n, rw, ram_sel, wr_prot} = ins;
    endtask

    // Protocol invariants on every instance, every cycle out of reset.
    task automatic inv(input string name, input logic [8:0] o, input state_t st);
        logic bad;
        bad = (!o[6] && !o[7]) || ((!o[7] || !o[6]) && o[8]) || (o[1] != (st == ACK));
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s invariant out=%b state=%s", name, o, st.name());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            inv("inv_ws1", out1, if1.dbg_state);
            inv("inv_ws0", out0, if0.dbg_state);
            inv("inv_ws3", out3, if3.dbg_state);
        end
    end

    // Delayed-DS write on the WAIT_STATES=0 instance.
    task automatic run_write(input logic prot, output int we_low, output int dtack_at);
        drive({5'b01101, prot});
        we_low   = 0;
        dtack_at = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (!out0[6]) we_low++;
            if (out0[1] && dtack_at < 0) dtack_at = i;
            if (i == 2) check(prot ? "wr_prot_access" : "wr_access", out0,
                              prot ? 9'b011101000 : 9'b010101000);
            if (i == 1) lds_n = 1'b0;
        end
        drive(6'b111100);
        step();
        check("wr_release", out0, IDL);
    endtask

    vec_t vecs[20];
    int   we_low, dtack_at, ce_at, oe_at, cnt1, cnt3, to1_at, to3_at, seen;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive(6'b111100);

        vecs[0]  = '{6'b111100, IDL,          IDLE};
        vecs[1]  = '{6'b000110, 9'b011110100, SELECT};
        vecs[2]  = '{6'b000110, 9'b001001100, ACCESS};
        vecs[3]  = '{6'b000110, 9'b001001100, ACCESS};
        vecs[4]  = '{6'b000110, 9'b001001110, ACK};
        vecs[5]  = '{6'b000110, 9'b001001110, ACK};
        vecs[6]  = '{6'b111100, IDL,          IDLE};
        vecs[7]  = '{6'b011010, 9'b011110000, SELECT};
        vecs[8]  = '{6'b011010, 9'b011110000, SELECT};
        vecs[9]  = '{6'b010010, 9'b010101000, ACCESS};
        vecs[10] = '{6'b010010, 9'b010101000, ACCESS};
        vecs[11] = '{6'b010010, 9'b011101010, ACK};
        vecs[12] = '{6'b111100, IDL,          IDLE};
        vecs[13] = '{6'b001110, 9'b011110100, SELECT};
        vecs[14] = '{6'b001100, 9'b001011100, ACCESS};
        vecs[15] = '{6'b001100, 9'b001011100, ACCESS};
        vecs[16] = '{6'b001100, 9'b001011110, ACK};
        vecs[17] = '{6'b111100, IDL,          IDLE};
        vecs[18] = '{6'b000100, IDL,          IDLE};
        vecs[19] = '{6'b111100, IDL,          IDLE};

        step();
        step();
        check("reset_ws1", out1, IDL);
        check("reset_ws0", out0, IDL);
        check("reset_ws3", out3, IDL);
        rst_n = 1'b1;
        step();

        // Table: word read, delayed-LDS byte write, ram_sel drop, no-hit cycle.
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].ins);
            step();
            check($sformatf("vec%0d", i), out1, vecs[i].exp);
            check_st($sformatf("vec%0d_state", i), if1.dbg_state, vecs[i].st);
        end

        // Byte write, WAIT_STATES=0: WE low one cycle, dtack three edges after go.
        run_write(1'b0, we_low, dtack_at);
        check_int("wr_we_low_cycles", we_low, 1);
        check_int("wr_dtack_edge", dtack_at, 3);
        step();
        run_write(1'b1, we_low, dtack_at);
        check_int("wrprot_we_low_cycles", we_low, 0);
        check_int("wrprot_dtack_edge", dtack_at, 3);
        step();

        // _AS negated in ACCESS, WAIT_STATES=3: abort, no dtack.
        drive(6'b000110);
        step();
        step();
        check("abort_in_access", out3, 9'b001001100);
        drive(6'b111100);
        step();
        check("abort_idle", out3, IDL);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out3[1]) seen++;
        end
        check_int("abort_no_dtack", seen, 0);

        // _AS stuck low: timeout at edge 64, then locked out until _AS goes high.
        drive(6'b000110);
        cnt1 = 0; cnt3 = 0; to1_at = -1; to3_at = -1;
        for (int i = 0; i < 70; i++) begin
            step();
            if (out1[0]) begin cnt1++; if (to1_at < 0) to1_at = i; end
            if (out3[0]) begin cnt3++; if (to3_at < 0) to3_at = i; end
            if (i == 64) check("timeout_outputs", out1, 9'b111110101);
        end
        check_int("timeout_edge_ws1", to1_at, 64);
        check_int("timeout_edge_ws3", to3_at, 64);
        check_int("timeout_pulses_ws1", cnt1, 1);
        check_int("timeout_pulses_ws3", cnt3, 1);
        check("timeout_no_restart", out1, IDL);
        drive(6'b111100);
        step();
        check("timeout_as_high", out1, IDL);
        drive(6'b000110);
        step();
        check("timeout_restart", out1, 9'b011110100);
        drive(6'b111100);
        step();
        step();

        // Asynchronous reset in the middle of ACK.
        drive(6'b000110);
        for (int i = 0; i < 4; i++) step();
        check("pre_reset_ack", out1, 9'b001001110);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_ws1", out1, IDL);
        check("async_reset_ws3", out3, IDL);
        drive(6'b111100);
        step();
        rst_n = 1'b1;
        step();
        drive(6'b000110);
        ce_at = -1; oe_at = -1; dtack_at = -1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (!out1[8] && ce_at < 0) ce_at = i;
            if (!out1[7] && oe_at < 0) oe_at = i;
            if (out1[1] && dtack_at < 0) dtack_at = i;
        end
        check_int("post_reset_ce_edge", ce_at, 0);
        check_int("post_reset_oe_edge", oe_at, 1);
        check_int("post_reset_dtack_edge", dtack_at, 3);
        drive(6'b111100);
        step();
        check("post_reset_release", out1, IDL);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
